enc_lbist_ctrl: RTL and testbench

Parametrised on-chip logic-BIST controller for the ADPCM encoder core. Generalises the single `scan_in0`/`scan_out0` chain to `NUM_CHAINS` parallel scan chains. Drives chains from an internal pseudo-random pattern generator (PRPG), sequences shift/capture cycles for a programmable pattern count, and compacts chain outputs into a multiple-input signature register (MISR). Sits between the chip test-control logic and the encoder's scan-stitched netlist.

---
 rtl/enc_lbist_pkg.sv | 25 ++
 rtl/enc_misr.sv | 33 +++
 rtl/enc_lbist_ctrl.sv | 133 +++++++++++++
 tb/tb_enc_lbist_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_lbist_pkg.sv
// Shared constants for the encoder logic-BIST controller: FSM states,
// PRPG seed/taps and MISR polynomial.
package enc_lbist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CAPTURE,
    S_UNLOAD,
    S_DONE
  } state_e;

  localparam int          PRPG_W    = 16;
  // x^16+x^14+x^13+x^11+1 -> feedback from bits 15,13,12,10
  localparam logic [15:0] PRPG_TAPS = 16'hB400;
  localparam logic [15:0] PRPG_SEED = 16'hACE1;

  localparam int          SIG_W     = 16;
  localparam logic [15:0] MISR_POLY = 16'h002D;

  function automatic logic [PRPG_W-1:0] prpg_step(input logic [PRPG_W-1:0] s);
    return {s[PRPG_W-2:0], ^(s & PRPG_TAPS)};
  endfunction

endpackage

// File: rtl/enc_misr.sv
// Multiple-input signature register with enable and synchronous clear.
module enc_misr
  import enc_lbist_pkg::*;
#(
  parameter int               WIDTH = SIG_W,
  parameter logic [WIDTH-1:0] POLY  = MISR_POLY,
  parameter int               N_IN  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [N_IN-1:0]  data_i,
  output logic [WIDTH-1:0] sig_o
);

  logic [WIDTH-1:0] sig_q, sig_d, data_ext;

  always_comb begin
    data_ext             = '0;
    data_ext[N_IN-1:0]   = data_i;
    sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ data_ext;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     sig_q <= '0;
    else if (clr_i)  sig_q <= '0;
    else if (en_i)   sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/enc_lbist_ctrl.sv
// Logic-BIST controller: PRPG-driven shift/capture sequencing over
// NUM_CHAINS scan chains with MISR compaction of the chain outputs.
module enc_lbist_ctrl
  import enc_lbist_pkg::*;
#(
  parameter int NUM_CHAINS = 4,
  parameter int CHAIN_LEN  = 64,
  parameter int PAT_W      = 8,
  parameter int MISR_W     = SIG_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [PAT_W-1:0]      num_patterns,
  input  logic [NUM_CHAINS-1:0] scan_out,
  output logic                  scan_en,
  output logic [NUM_CHAINS-1:0] scan_in,
  output logic                  busy,
  output logic                  done,
  output logic [MISR_W-1:0]     signature
);

  localparam int               CNT_W   = $clog2(CHAIN_LEN);
  localparam logic [CNT_W-1:0] SH_LAST = CNT_W'(CHAIN_LEN - 1);

  state_e              state_q;
  logic [PRPG_W-1:0]   prpg_q;
  logic [PAT_W-1:0]    np_q, pat_q, pat_inc;
  logic [CNT_W-1:0]    sh_q;
  logic                scan_en_q, busy_q, done_q;
  logic                misr_clr, misr_en;

  assign pat_inc = pat_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      prpg_q    <= PRPG_SEED;
      np_q      <= '0;
      pat_q     <= '0;
      sh_q      <= '0;
      scan_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        state_q   <= S_IDLE;
        scan_en_q <= 1'b0;
        busy_q    <= 1'b0;
        sh_q      <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              np_q   <= num_patterns;
              pat_q  <= '0;
              sh_q   <= '0;
              prpg_q <= PRPG_SEED;
              busy_q <= 1'b1;
              if (num_patterns == '0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q   <= S_SHIFT;
                scan_en_q <= 1'b1;
              end
            end
          end
          S_SHIFT: begin
            prpg_q <= prpg_step(prpg_q);
            if (sh_q == SH_LAST) begin
              sh_q      <= '0;
              state_q   <= S_CAPTURE;
              scan_en_q <= 1'b0;
            end else begin
              sh_q <= sh_q + 1'b1;
            end
          end
          S_CAPTURE: begin
            pat_q     <= pat_inc;
            scan_en_q <= 1'b1;
            state_q   <= (pat_inc == np_q) ? S_UNLOAD : S_SHIFT;
          end
          S_UNLOAD: begin
            if (sh_q == SH_LAST) begin
              sh_q      <= '0;
              state_q   <= S_DONE;
              scan_en_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              sh_q <= sh_q + 1'b1;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            scan_en_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // The first SHIFT window (pat_q == 0) unloads uninitialised flops, so it is masked.
  assign misr_clr = (state_q == S_IDLE) && start;
  assign misr_en  = !abort &&
                    (((state_q == S_SHIFT) && (pat_q != '0)) || (state_q == S_UNLOAD));

  enc_misr #(
    .WIDTH (MISR_W),
    .POLY  (MISR_W'(MISR_POLY)),
    .N_IN  (NUM_CHAINS)
  ) u_misr (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (misr_clr),
    .en_i   (misr_en),
    .data_i (scan_out),
    .sig_o  (signature)
  );

  assign scan_en = scan_en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign scan_in = (state_q == S_SHIFT) ? prpg_q[NUM_CHAINS-1:0] : '0;

endmodule

// File: tb/tb_enc_lbist_ctrl.sv
// Directed bench for enc_lbist_ctrl with 4 chains of 8 flops and a
// bench-side chain model (inverting capture) feeding scan_out.
module tb_enc_lbist_ctrl;

  localparam int NC = 4, L = 8, PW = 8, MW = 16;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [PW-1:0] num_patterns = '0;
  logic [NC-1:0] scan_out, scan_in;
  logic          scan_en, busy, done;
  logic [MW-1:0] signature;

  int vecs = 0, errs = 0;

  logic          chain_mode = 1'b0, load_req = 1'b0;
  logic [L-1:0]  load_v = '0;
  logic [L-1:0]  chain [NC];
  logic          se_s = 1'b0, cap_s = 1'b0;
  logic [NC-1:0] si_s = '0;

  always #5 clk = ~clk;

  enc_lbist_ctrl #(.NUM_CHAINS(NC), .CHAIN_LEN(L), .PAT_W(PW), .MISR_W(MW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .num_patterns(num_patterns), .scan_out(scan_out), .scan_en(scan_en),
    .scan_in(scan_in), .busy(busy), .done(done), .signature(signature)
  );

  // Chain model: shift MSB-out when scan_en, invert contents on a capture cycle.
  always_comb begin
    scan_out = '0;
    if (chain_mode)
      for (int i = 0; i < NC; i++) scan_out[i] = chain[i][L-1];
  end

  always @(negedge clk) begin
    se_s  <= scan_en;
    si_s  <= scan_in;
    cap_s <= busy & ~scan_en & ~done;
  end

  always @(posedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (load_req)   chain[i] <= load_v ^ L'(i);
      else if (se_s)  chain[i] <= {chain[i][L-2:0], si_s[i]};
      else if (cap_s) chain[i] <= ~chain[i];
    end
  end

  function automatic logic [15:0] lfsr(input logic [15:0] p);
    return {p[14:0], p[15] ^ p[13] ^ p[12] ^ p[10]};
  endfunction

  function automatic logic [15:0] mstep(input logic [15:0] m, input logic [NC-1:0] d);
    return {m[14:0], 1'b0} ^ (m[15] ? 16'h002D : 16'h0000) ^ 16'(d);
  endfunction

  task automatic model_sig(input int p_cnt, input logic [L-1:0] v, output logic [15:0] sig);
    logic [L-1:0]  ch [NC];
    logic [15:0]   p;
    logic [NC-1:0] so;
    p = 16'hACE1; sig = '0;
    for (int i = 0; i < NC; i++) ch[i] = v ^ L'(i);
    for (int pt = 0; pt < p_cnt; pt++) begin
      for (int k = 0; k < L; k++) begin
        for (int i = 0; i < NC; i++) so[i] = ch[i][L-1];
        if (pt != 0) sig = mstep(sig, so);
        for (int i = 0; i < NC; i++) ch[i] = {ch[i][L-2:0], p[i]};
        p = lfsr(p);
      end
      for (int i = 0; i < NC; i++) ch[i] = ~ch[i];
    end
    for (int k = 0; k < L; k++) begin
      for (int i = 0; i < NC; i++) so[i] = ch[i][L-1];
      sig = mstep(sig, so);
      for (int i = 0; i < NC; i++) ch[i] = {ch[i][L-2:0], 1'b0};
    end
  endtask

  task automatic load_chains(input logic [L-1:0] v);
    @(posedge clk); #1; load_v = v; load_req = 1'b1;
    @(posedge clk); #1; load_req = 1'b0;
  endtask

  // Drives start during "cycle 0".
  task automatic go(input int p);
    @(posedge clk); #1; start = 1'b1; num_patterns = PW'(p);
  endtask

  // Steps from cycle 1, returns first cycle with done=1 or -1 on budget expiry.
  task automatic wait_done(input int budget, output int dc);
    dc = -1;
    for (int c = 1; c <= budget && dc < 0; c++) begin
      @(posedge clk); #1; if (c == 1) start = 1'b0;
      @(negedge clk);
      if (done === 1'b1) dc = c;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1; reset = 1'b0; #1;
    vecs++;
    if ({scan_en, scan_in, busy, done, signature} !== '0) begin
      errs++;
      $display("FAIL reset_values: got se=%b si=%h busy=%b done=%b sig=%h, expected all 0",
               scan_en, scan_in, busy, done, signature);
    end
    repeat (2) @(posedge clk); #1; reset = 1'b1;
  endtask

  task automatic test_zero_out();
    logic [15:0] p;
    logic        e_se, e_busy, e_done;
    logic [NC-1:0] e_si;
    chain_mode = 1'b0; p = 16'hACE1;
    go(3);
    for (int c = 1; c <= 38; c++) begin
      @(posedge clk); #1; if (c == 1) start = 1'b0;
      @(negedge clk);
      e_se   = (c <= 35) && (c != 9) && (c != 18) && (c != 27);
      e_busy = (c <= 36);
      e_done = (c == 36);
      e_si   = (e_se && c <= 27) ? p[NC-1:0] : '0;
      if (c != 9 && c != 18 && c != 27) begin
        vecs++;
        if ({scan_en, busy, done, scan_in} !== {e_se, e_busy, e_done, e_si}) begin
          errs++;
          $display("FAIL zero_out_cycle%0d: got se/busy/done/si=%b%b%b/%h expected %b%b%b/%h",
                   c, scan_en, busy, done, scan_in, e_se, e_busy, e_done, e_si);
        end
      end else begin
        vecs++;
        if ({scan_en, busy, done} !== 3'b010) begin
          errs++;
          $display("FAIL capture_cycle%0d: got se/busy/done=%b%b%b expected 010",
                   c, scan_en, busy, done);
        end
      end
      if (e_se && c <= 27) p = lfsr(p);
    end
    vecs++;
    if (signature !== 16'h0000) begin
      errs++; $display("FAIL zero_out_sig: got %h expected 0000", signature);
    end
  endtask

  task automatic test_signature();
    int            ptab [3] = '{3, 1, 5};
    logic [L-1:0]  vtab [3] = '{8'hC3, 8'h5A, 8'h0F};
    logic [15:0]   exp_sig;
    int            dc;
    chain_mode = 1'b1;
    for (int t = 0; t < 3; t++) begin
      load_chains(vtab[t]);
      model_sig(ptab[t], vtab[t], exp_sig);
      go(ptab[t]);
      wait_done(200, dc);
      vecs++;
      if (dc !== ptab[t] * (L + 1) + L + 1) begin
        errs++; $display("FAIL sig_done_cycle_P%0d: got %0d expected %0d", ptab[t], dc, ptab[t] * (L + 1) + L + 1);
      end
      vecs++;
      if (signature !== exp_sig) begin
        errs++; $display("FAIL signature_P%0d: got %h expected %h", ptab[t], signature, exp_sig);
      end
    end
  endtask

  task automatic test_p0();
    chain_mode = 1'b1;
    go(0);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1; if (c == 1) start = 1'b0;
      @(negedge clk);
      vecs++;
      if ({scan_en, busy, done, signature} !== {1'b0, c == 1, c == 1, 16'h0000}) begin
        errs++;
        $display("FAIL p0_cycle%0d: got se/busy/done=%b%b%b sig=%h expected 0%b%b sig=0000",
                 c, scan_en, busy, done, signature, c == 1, c == 1);
      end
    end
  endtask

  task automatic test_abort();
    int dc;
    chain_mode = 1'b0;
    go(3);
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (c == 12) abort = 1'b1;
      if (c == 13) begin abort = 1'b0; start = 1'b1; num_patterns = 8'd3; end
      @(negedge clk);
      if (c == 12 || c == 13) begin
        vecs++;
        if ({busy, scan_en, done} !== {c == 12, c == 12, 1'b0}) begin
          errs++;
          $display("FAIL abort_cycle%0d: got busy/se/done=%b%b%b expected %b%b0",
                   c, busy, scan_en, done, c == 12, c == 12);
        end
      end
    end
    wait_done(60, dc);
    vecs++;
    if (dc !== 36) begin
      errs++; $display("FAIL after_abort_done: got %0d expected 36", dc);
    end
    vecs++;
    if (signature !== 16'h0000) begin
      errs++; $display("FAIL after_abort_sig: got %h expected 0000", signature);
    end
  endtask

  task automatic test_back_to_back();
    logic e_se, e_busy, e_done;
    chain_mode = 1'b0;
    go(3);
    for (int c = 1; c <= 57; c++) begin
      @(posedge clk); #1;
      if (c == 1 || c == 6 || c == 38) start = 1'b0;
      if (c == 5) begin start = 1'b1; num_patterns = 8'd1; end
      if (c == 20) num_patterns = 8'd7;
      if (c == 37) begin start = 1'b1; num_patterns = 8'd1; end
      @(negedge clk);
      // Second run: start in cycle 37, one pattern -> SHIFT 38..45, CAPTURE 46, UNLOAD 47..54.
      e_se   = ((c <= 35) && (c != 9) && (c != 18) && (c != 27)) ||
               ((c >= 38) && (c <= 54) && (c != 46));
      e_busy = (c <= 36) || ((c >= 38) && (c <= 55));
      e_done = (c == 36) || (c == 55);
      vecs++;
      if ({scan_en, busy, done} !== {e_se, e_busy, e_done}) begin
        errs++;
        $display("FAIL b2b_cycle%0d: got se/busy/done=%b%b%b expected %b%b%b",
                 c, scan_en, busy, done, e_se, e_busy, e_done);
      end
    end
  endtask

  task automatic test_max_patterns();
    int dc;
    chain_mode = 1'b0;
    go(255);
    wait_done(2400, dc);
    vecs++;
    if (dc !== 255 * (L + 1) + L + 1) begin
      errs++; $display("FAIL max_patterns_done: got %0d expected %0d", dc, 255 * (L + 1) + L + 1);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp_sig;
    int          dc;
    chain_mode = 1'b1;
    load_chains(8'h96);
    go(3);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1; if (c == 1) start = 1'b0;
    end
    reset = 1'b0; #1;
    vecs++;
    if ({scan_en, scan_in, busy, done, signature} !== '0) begin
      errs++;
      $display("FAIL reset_mid: got se=%b si=%h busy=%b done=%b sig=%h, expected all 0",
               scan_en, scan_in, busy, done, signature);
    end
    #2; reset = 1'b1;
    load_chains(8'h77);
    model_sig(2, 8'h77, exp_sig);
    go(2);
    wait_done(100, dc);
    vecs++;
    if (dc !== 2 * (L + 1) + L + 1) begin
      errs++; $display("FAIL reset_mid_rerun_done: got %0d expected %0d", dc, 2 * (L + 1) + L + 1);
    end
    vecs++;
    if (signature !== exp_sig) begin
      errs++; $display("FAIL reset_mid_rerun_sig: got %h expected %h", signature, exp_sig);
    end
  endtask

  initial begin
    test_reset();
    test_zero_out();
    test_signature();
    test_p0();
    test_abort();
    test_back_to_back();
    test_max_patterns();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
